// File: rtl/backend_pipe_chain.sv
// backend_pipe_chain: parametrised backend register chain (EX .. WB).
//
// Holds STAGES slots (0 = youngest/EX, STAGES-1 = oldest/WB). Each slot carries a valid bit,
// an opaque control word, a data word and an issue sequence tag. Per-stage stall and clear
// requests are resolved into an effective stall vector and a kill mask. A stall freezes the
// requesting slot and everything younger, and inserts a bubble behind it. A clear kills
// everything younger than the oldest requesting slot, plus that slot when kill_self_i is set.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   issue_valid_i/_o    issue handshake (issue_ready_o = ~stall_o[0])
//   issue_ctrl_i/data_i fields of the issued instruction
//   stall_req_i         per-stage stall request (top bit ignored)
//   clr_req_i           per-stage clear request, kills strictly younger slots
//   kill_self_i         qualifies clr_req_i, also kills the requesting slot
//   upd_en_i/upd_data_i per-stage result write-back
//   stall_o             effective stall per stage (combinational)
//   valid_o/ctrl_o/data_o/seq_o  registered slot contents; data_o are the forwarding taps
//   retire_valid_o      oldest slot valid (combinational from state)
//
// Optional feature, macro BACKEND_PIPE_PERF_EN: adds perf_stall_cnt_o (per-stage cycles
// stalled while valid) and perf_bubble_cnt_o (cycles with the oldest slot empty), both
// saturating 32-bit counters.
module backend_pipe_chain #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned CTRL_W = 64,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEQ_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [CTRL_W-1:0]        issue_ctrl_i,
  input  logic [DATA_W-1:0]        issue_data_i,
  input  logic [STAGES-1:0]        stall_req_i,
  input  logic [STAGES-1:0]        clr_req_i,
  input  logic [STAGES-1:0]        kill_self_i,
  input  logic [STAGES-1:0]        upd_en_i,
  input  logic [STAGES*DATA_W-1:0] upd_data_i,
  output logic [STAGES-1:0]        stall_o,
  output logic [STAGES-1:0]        valid_o,
  output logic [STAGES*CTRL_W-1:0] ctrl_o,
  output logic [STAGES*DATA_W-1:0] data_o,
  output logic [STAGES*SEQ_W-1:0]  seq_o,
  output logic                     retire_valid_o
`ifdef BACKEND_PIPE_PERF_EN
  ,
  output logic [STAGES*32-1:0]     perf_stall_cnt_o,
  output logic [31:0]              perf_bubble_cnt_o
`endif
);

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
  logic [STAGES-1:0][SEQ_W-1:0]  seq_q, seq_d;
  logic [SEQ_W-1:0]              seq_cnt_q, seq_cnt_d;

  logic [STAGES-1:0]             stall;
  logic [STAGES-1:0]             killed;
  logic                          issue_kill;
  logic [STAGES-1:0][DATA_W-1:0] upd_data;
  logic [STAGES-1:0][DATA_W-1:0] fwd_data;

  assign upd_data = upd_data_i;

  // A stall request at stage j freezes stages 0..j; the oldest stage never stalls.
  always_comb begin
    stall = '0;
    for (int i = 0; i < int'(STAGES) - 1; i++) begin
      stall[i] = |(stall_req_i[STAGES-2:0] >> i);
    end
  end

  // Ascending scan: the highest clearing stage overwrites the mask last, so the oldest wins.
  always_comb begin
    killed     = '0;
    issue_kill = |clr_req_i;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (clr_req_i[i]) begin
        for (int j = 0; j < int'(STAGES); j++) begin
          killed[j] = (j < i) || ((j == i) && kill_self_i[i]);
        end
      end
    end
  end

  // Data word leaving each slot, with the execution-unit result override.
  always_comb begin
    for (int i = 0; i < int'(STAGES); i++) begin
      fwd_data[i] = upd_en_i[i] ? upd_data[i] : data_q[i];
    end
  end

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    seq_d     = seq_q;
    seq_cnt_d = seq_cnt_q;

    if (stall[0]) begin
      valid_d[0] = valid_q[0] & ~killed[0];
      if (upd_en_i[0]) data_d[0] = upd_data[0];
    end else begin
      valid_d[0] = issue_valid_i & ~issue_kill;
      ctrl_d[0]  = issue_ctrl_i;
      data_d[0]  = issue_data_i;
      seq_d[0]   = seq_cnt_q;
    end

    for (int i = 1; i < int'(STAGES); i++) begin
      if (stall[i]) begin
        valid_d[i] = valid_q[i] & ~killed[i];
        if (upd_en_i[i]) data_d[i] = upd_data[i];
      end else begin
        // A stalled predecessor stays put, so a bubble enters here.
        valid_d[i] = valid_q[i-1] & ~killed[i-1] & ~stall[i-1];
        ctrl_d[i]  = ctrl_q[i-1];
        data_d[i]  = fwd_data[i-1];
        seq_d[i]   = seq_q[i-1];
      end
    end

    // The tag is consumed even when the handshake is killed in the same cycle.
    if (issue_valid_i && !stall[0]) seq_cnt_d = seq_cnt_q + SEQ_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      ctrl_q    <= '0;
      data_q    <= '0;
      seq_q     <= '0;
      seq_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      seq_q     <= seq_d;
      seq_cnt_q <= seq_cnt_d;
    end
  end

  assign stall_o        = stall;
  assign issue_ready_o  = ~stall[0];
  assign valid_o        = valid_q;
  assign ctrl_o         = ctrl_q;
  assign data_o         = data_q;
  assign seq_o          = seq_q;
  assign retire_valid_o = valid_q[STAGES-1];

`ifdef BACKEND_PIPE_PERF_EN
  logic [STAGES-1:0][31:0] stall_cnt_q;
  logic [31:0]             bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (stall[i] && valid_q[i] && (stall_cnt_q[i] != '1)) begin
          stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
        end
      end
      if (!valid_q[STAGES-1] && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o  = stall_cnt_q;
  assign perf_bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_backend_pipe_chain.sv
module tb_backend_pipe_chain;

  localparam int S  = 4;
  localparam int CW = 64;
  localparam int DW = 32;
  localparam int SW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic            issue_ready;
  logic [CW-1:0]   issue_ctrl;
  logic [DW-1:0]   issue_data;
  logic [S-1:0]    stall_req, clr_req, kill_self, upd_en;
  logic [S*DW-1:0] upd_data;
  logic [S-1:0]    stall_o, valid_o;
  logic [S*CW-1:0] ctrl_o;
  logic [S*DW-1:0] data_o;
  logic [S*SW-1:0] seq_o;
  logic            retire_valid;

  always #5 clk = ~clk;

  backend_pipe_chain #(
    .STAGES(S), .CTRL_W(CW), .DATA_W(DW), .SEQ_W(SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_ready_o (issue_ready),
    .issue_ctrl_i  (issue_ctrl),
    .issue_data_i  (issue_data),
    .stall_req_i   (stall_req),
    .clr_req_i     (clr_req),
    .kill_self_i   (kill_self),
    .upd_en_i      (upd_en),
    .upd_data_i    (upd_data),
    .stall_o       (stall_o),
    .valid_o       (valid_o),
    .ctrl_o        (ctrl_o),
    .data_o        (data_o),
    .seq_o         (seq_o),
    .retire_valid_o(retire_valid)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: an array of slots plus the issue tag counter.
  logic          m_valid [S];
  logic [CW-1:0] m_ctrl  [S];
  logic [DW-1:0] m_data  [S];
  logic [SW-1:0] m_seq   [S];
  logic [SW-1:0] m_cnt;

  typedef struct {
    logic [S-1:0] st;
    logic [S-1:0] clr;
    logic [S-1:0] ks;
    logic         iv;
    logic [S-1:0] e_stall;
    logic         e_ready;
    logic [S-1:0] e_valid;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Highest stage that freezes (stalls) this cycle, -1 if none.
  function automatic int frozen_top();
    int f = -1;
    for (int j = 0; j < S - 1; j++) if (stall_req[j]) f = j;
    return f;
  endfunction

  task automatic model_step();
    int f, k;
    logic          kl [S];
    logic          nv [S];
    logic [CW-1:0] nc [S];
    logic [DW-1:0] nd [S];
    logic [SW-1:0] ns [S];
    f = frozen_top();
    k = -1;
    for (int j = 0; j < S; j++) if (clr_req[j]) k = j;
    for (int i = 0; i < S; i++) begin
      kl[i] = (k >= 0) && ((i < k) || ((i == k) && kill_self[i]));
      nv[i] = m_valid[i]; nc[i] = m_ctrl[i]; nd[i] = m_data[i]; ns[i] = m_seq[i];
    end
    if (!rst_n) begin
      for (int i = 0; i < S; i++) begin
        nv[i] = 1'b0; nc[i] = '0; nd[i] = '0; ns[i] = '0;
      end
      m_cnt = '0;
    end else begin
      for (int i = 1; i < S; i++) begin
        if (i <= f) begin
          nv[i] = m_valid[i] && !kl[i];
          if (upd_en[i]) nd[i] = upd_data[i*DW +: DW];
        end else begin
          // Slot i-1 moves up only if it is not frozen; otherwise slot i gets a bubble.
          nv[i] = m_valid[i-1] && !kl[i-1] && ((i - 1) > f);
          nc[i] = m_ctrl[i-1];
          nd[i] = upd_en[i-1] ? upd_data[(i-1)*DW +: DW] : m_data[i-1];
          ns[i] = m_seq[i-1];
        end
      end
      if (f >= 0) begin
        nv[0] = m_valid[0] && !kl[0];
        if (upd_en[0]) nd[0] = upd_data[0 +: DW];
      end else begin
        nv[0] = issue_valid && (k < 0);
        nc[0] = issue_ctrl;
        nd[0] = issue_data;
        ns[0] = m_cnt;
        if (issue_valid) m_cnt = m_cnt + 1'b1;
      end
    end
    for (int i = 0; i < S; i++) begin
      m_valid[i] = nv[i]; m_ctrl[i] = nc[i]; m_data[i] = nd[i]; m_seq[i] = ns[i];
    end
  endtask

  task automatic check_state();
    logic [S-1:0] ev;
    for (int i = 0; i < S; i++) ev[i] = m_valid[i];
    check("valid", 256'(valid_o), 256'(ev));
    check("retire", 256'(retire_valid), 256'(ev[S-1]));
    for (int i = 0; i < S; i++) begin
      if (m_valid[i]) begin
        check($sformatf("ctrl[%0d]", i), 256'(ctrl_o[i*CW +: CW]), 256'(m_ctrl[i]));
        check($sformatf("data[%0d]", i), 256'(data_o[i*DW +: DW]), 256'(m_data[i]));
        check($sformatf("seq[%0d]", i), 256'(seq_o[i*SW +: SW]), 256'(m_seq[i]));
      end
    end
  endtask

  // Inputs are already driven; check combinational outputs, advance model and DUT one edge.
  task automatic step();
    int f;
    logic [S-1:0] es;
    #1;
    f = frozen_top();
    for (int i = 0; i < S; i++) es[i] = (i <= f);
    check("stall_o", 256'(stall_o), 256'(es));
    check("ready", 256'(issue_ready), 256'(f < 0));
    model_step();
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle();
    rst_n       = 1'b1;
    issue_valid = 1'b0;
    issue_ctrl  = '0;
    issue_data  = '0;
    stall_req   = '0;
    clr_req     = '0;
    kill_self   = '0;
    upd_en      = '0;
    upd_data    = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic issue_one();
    issue_valid = 1'b1;
    issue_ctrl  = {$urandom, $urandom};
    issue_data  = $urandom;
    step();
  endtask

  task automatic fill();
    idle();
    for (int n = 0; n < S; n++) issue_one();
  endtask

  function automatic logic rbit(input int unsigned n);
    return ($urandom_range(n - 1, 0) == 0);
  endfunction

  initial begin
    //        st       clr      ks       iv    e_stall  rdy   e_valid
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1111};
    tbl[1]  = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0011, 1'b0, 4'b1011};
    tbl[2]  = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1111};
    tbl[3]  = '{4'b0000, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1000};
    tbl[4]  = '{4'b0010, 4'b0110, 4'b0100, 1'b1, 4'b0011, 1'b0, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b1, 4'b1100};
    tbl[7]  = '{4'b0000, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1110};
    tbl[8]  = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0111, 1'b0, 4'b0111};
    tbl[9]  = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b1101};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1110};

    idle();
    for (int i = 0; i < S; i++) begin
      m_valid[i] = 1'b0; m_ctrl[i] = '0; m_data[i] = '0; m_seq[i] = '0;
    end
    m_cnt = '0;
    @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    #1;
    check("rst_valid", 256'(valid_o), 256'(0));
    check("rst_ctrl", 256'(ctrl_o), 256'(0));
    check("rst_data", 256'(data_o), 256'(0));
    check("rst_seq", 256'(seq_o), 256'(0));
    check("rst_stall", 256'(stall_o), 256'(0));
    check("rst_ready", 256'(issue_ready), 256'(1));
    check("rst_retire", 256'(retire_valid), 256'(0));

    // Table-driven: each record applied to a full chain.
    foreach (tbl[r]) begin
      fill();
      stall_req   = tbl[r].st;
      clr_req     = tbl[r].clr;
      kill_self   = tbl[r].ks;
      issue_valid = tbl[r].iv;
      issue_ctrl  = {$urandom, $urandom};
      issue_data  = $urandom;
      #1;
      check($sformatf("tbl%0d_stall", r), 256'(stall_o), 256'(tbl[r].e_stall));
      check($sformatf("tbl%0d_ready", r), 256'(issue_ready), 256'(tbl[r].e_ready));
      step();
      check($sformatf("tbl%0d_valid", r), 256'(valid_o), 256'(tbl[r].e_valid));
    end

    // Streaming: six back-to-back issues retire four cycles later, in tag order.
    do_reset();
    for (int t = 0; t < 12; t++) begin
      issue_valid = (t < 6);
      issue_ctrl  = 64'(t);
      issue_data  = 32'(100 + t);
      step();
      check("stream_retire", 256'(retire_valid), 256'((t + 1 >= 4) && (t + 1 <= 9)));
      if ((t + 1 >= 4) && (t + 1 <= 9)) begin
        check("stream_seq", 256'(seq_o[3*SW +: SW]), 256'(t - 3));
        check("stream_data", 256'(data_o[3*DW +: DW]), 256'(100 + t - 3));
      end
    end

    // Clear at stage 2 with a same-cycle issue: issue is dropped but consumes tag 4.
    do_reset();
    fill();
    clr_req     = 4'b0100;
    issue_valid = 1'b1;
    step();
    check("clr_valid", 256'(valid_o), 256'(4'b1000));
    check("clr_seq3", 256'(seq_o[3*SW +: SW]), 256'(1));
    idle();
    issue_one();
    check("clr_next_tag", 256'(seq_o[0 +: SW]), 256'(5));

    // Stalled slot 1 takes a result update in place.
    fill();
    stall_req           = 4'b0010;
    upd_en              = 4'b0010;
    upd_data[DW +: DW]  = 32'hDEADBEEF;
    step();
    check("upd_data1", 256'(data_o[DW +: DW]), 256'(32'hDEADBEEF));
    idle();

    // Two-cycle stall at stage 1 with the chain full.
    fill();
    issue_valid = 1'b1;
    stall_req   = 4'b0010;
    step();
    check("st2_ready_a", 256'(issue_ready), 256'(0));
    step();
    check("st2_valid", 256'(valid_o), 256'(4'b0011));
    idle();

    // Reset mid-flight with three valid slots.
    do_reset();
    for (int n = 0; n < 3; n++) issue_one();
    check("mid_valid", 256'(valid_o), 256'(4'b0111));
    rst_n       = 1'b0;
    issue_valid = 1'b1;
    stall_req   = 4'b0001;
    clr_req     = 4'b0010;
    step();
    check("mid_rst_valid", 256'(valid_o), 256'(0));
    idle();
    issue_one();
    check("mid_rst_tag", 256'(seq_o[0 +: SW]), 256'(0));

    // Tag wrap after 64 handshakes.
    do_reset();
    for (int n = 0; n < 65; n++) begin
      issue_one();
      if (n == 63) check("wrap_tag63", 256'(seq_o[0 +: SW]), 256'(63));
      if (n == 64) check("wrap_tag0", 256'(seq_o[0 +: SW]), 256'(0));
    end

    // Randomized traffic against the model.
    idle();
    for (int c = 0; c < 2000; c++) begin
      rst_n       = !rbit(200);
      issue_valid = !rbit(4);
      issue_ctrl  = {$urandom, $urandom};
      issue_data  = $urandom;
      for (int i = 0; i < S; i++) begin
        stall_req[i] = rbit(8);
        clr_req[i]   = rbit(12);
        kill_self[i] = rbit(2);
        upd_en[i]    = rbit(4);
        upd_data[i*DW +: DW] = $urandom;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
